// File: rtl/brentkung_io_stage_if.sv
// Handshake bundle for brentkung_io_stage: operand input port and registered result port.
// The master drives operands and result back-pressure; the slave is the I/O stage.
interface brentkung_io_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        out_carry;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );
endinterface

// File: rtl/brentkung_io_stage.sv
// I/O stage around a combinational 12-bit adder: operand FIFO feeding the interleaved
// operand bus, a registered valid/ready result port and saturating statistics counters.
module brentkung_io_stage #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  brentkung_io_stage_if.slave  io,
  output logic [23:0]          adder_inputs_o,
  input  logic [12:0]          adder_outs_i,
  output logic [CNT_W-1:0]     op_count_o,
  output logic [CNT_W-1:0]     carry_count_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  logic [23:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [11:0]      out_sum_q, out_sum_d;
  logic             out_carry_q, out_carry_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [CNT_W-1:0] carry_count_q, carry_count_d;

  logic        empty, full, push, cap, handoff;
  logic [23:0] head;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCnt);
  assign head    = mem_q[rd_ptr_q];
  assign push    = io.in_valid && !full;
  // Capture needs a free (or freeing) result register; full FIFO never takes a same-edge push.
  assign cap     = !empty && (!out_valid_q || io.out_ready);
  assign handoff = out_valid_q && io.out_ready;

  always_comb begin
    adder_inputs_o = '0;
    if (!empty) begin
      for (int i = 0; i < 12; i++) begin
        adder_inputs_o[2*i]   = head[12+i];
        adder_inputs_o[2*i+1] = head[i];
      end
    end
  end

  always_comb begin
    wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d      = cap ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d       = count_q;
    out_valid_d   = out_valid_q;
    out_sum_d     = out_sum_q;
    out_carry_d   = out_carry_q;
    op_count_d    = op_count_q;
    carry_count_d = carry_count_q;

    unique case ({push, cap})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (cap) begin
      out_valid_d = 1'b1;
      out_sum_d   = adder_outs_i[11:0];
      out_carry_d = adder_outs_i[12];
    end else if (handoff) begin
      out_valid_d = 1'b0;
    end

    if (handoff) begin
      if (!(&op_count_q)) op_count_d = op_count_q + CNT_W'(1);
      if (out_carry_q && !(&carry_count_q)) carry_count_d = carry_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= '0;
      out_carry_q   <= 1'b0;
      op_count_q    <= '0;
      carry_count_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= {io.in_a, io.in_b};
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      out_carry_q   <= out_carry_d;
      op_count_q    <= op_count_d;
      carry_count_q <= carry_count_d;
    end
  end

  assign io.in_ready     = !full;
  assign io.out_valid    = out_valid_q;
  assign io.out_sum      = out_sum_q;
  assign io.out_carry    = out_carry_q;
  assign op_count_o      = op_count_q;
  assign carry_count_o   = carry_count_q;

endmodule

// File: tb/tb_brentkung_io_stage.sv
// Self-checking bench for brentkung_io_stage: fixed vectors, hand sequences for back-pressure,
// mid-operation reset and counter saturation, and random traffic against a queue-based model.
module tb_brentkung_io_stage;

  localparam int Depth = 2;

  logic        clk;
  logic        rst_n;
  logic [23:0] adder_in, s_adder_in;
  logic [12:0] adder_out, s_adder_out;
  logic [15:0] op_cnt, car_cnt;
  logic [3:0]  s_op, s_car;

  int checks = 0;
  int errors = 0;

  brentkung_io_stage_if bus ();
  brentkung_io_stage_if sat ();

  function automatic logic [12:0] add_model(logic [23:0] v);
    logic [11:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a[i] = v[2*i];
      b[i] = v[2*i+1];
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign adder_out   = add_model(adder_in);
  assign s_adder_out = add_model(s_adder_in);

  brentkung_io_stage #(.FIFO_DEPTH(Depth), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .io             (bus),
    .adder_inputs_o (adder_in),
    .adder_outs_i   (adder_out),
    .op_count_o     (op_cnt),
    .carry_count_o  (car_cnt)
  );

  brentkung_io_stage #(.FIFO_DEPTH(2), .CNT_W(4)) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .io             (sat),
    .adder_inputs_o (s_adder_in),
    .adder_outs_i   (s_adder_out),
    .op_count_o     (s_op),
    .carry_count_o  (s_car)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending operand pairs, result register, handoff tallies.
  logic [23:0] mq[$];
  logic        m_valid;
  logic [11:0] m_sum;
  logic        m_carry;
  int          m_ops, m_carries;

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0; m_sum = '0; m_carry = 1'b0; m_ops = 0; m_carries = 0;
  endtask

  task automatic model_step();
    logic [23:0] e;
    logic [12:0] r;
    bit handoff, cap, push;
    handoff = m_valid && bus.out_ready;
    cap     = (mq.size() > 0) && (!m_valid || bus.out_ready);
    push    = bus.in_valid && (mq.size() < Depth);
    if (handoff) begin
      m_ops++;
      if (m_carry) m_carries++;
    end
    if (cap) begin
      e = mq.pop_front();
      r = {1'b0, e[23:12]} + {1'b0, e[11:0]};
      m_sum = r[11:0]; m_carry = r[12]; m_valid = 1'b1;
    end else if (handoff) begin
      m_valid = 1'b0;
    end
    if (push) mq.push_back({bus.in_a, bus.in_b});
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag);
    logic [23:0] exp_bus;
    logic [23:0] h;
    exp_bus = '0;
    if (mq.size() > 0) begin
      h = mq[0];
      for (int i = 0; i < 12; i++) begin
        exp_bus[2*i]   = h[12+i];
        exp_bus[2*i+1] = h[i];
      end
    end
    check({tag, "_in_ready"},  {31'd0, bus.in_ready},  {31'd0, mq.size() < Depth});
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, {31'd0, m_valid});
    check({tag, "_out_sum"},   {20'd0, bus.out_sum},   {20'd0, m_sum});
    check({tag, "_out_carry"}, {31'd0, bus.out_carry}, {31'd0, m_carry});
    check({tag, "_adder_in"},  {8'd0, adder_in},       {8'd0, exp_bus});
    check({tag, "_op_count"},  {16'd0, op_cnt},        (m_ops > 65535) ? 32'd65535 : m_ops);
    check({tag, "_carry_cnt"}, {16'd0, car_cnt},
          (m_carries > 65535) ? 32'd65535 : m_carries);
  endtask

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [23:0] exp_bus;
    logic [11:0] exp_sum;
    logic        exp_carry;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{12'hFFF, 12'h001, 24'h555557, 12'h000, 1'b1};
    vecs[1] = '{12'hAAA, 12'h555, 24'h666666, 12'hFFF, 1'b0};
    vecs[2] = '{12'hFFF, 12'h000, 24'h555555, 12'hFFF, 1'b0};
    vecs[3] = '{12'h000, 12'hFFF, 24'hAAAAAA, 12'hFFF, 1'b0};
    vecs[4] = '{12'h800, 12'h800, 24'hC00000, 12'h000, 1'b1};
    vecs[5] = '{12'hFFF, 12'hFFF, 24'hFFFFFF, 12'hFFE, 1'b1};
    vecs[6] = '{12'h000, 12'h000, 24'h000000, 12'h000, 1'b0};
    vecs[7] = '{12'h001, 12'h000, 24'h000001, 12'h001, 1'b0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    sat.in_valid = 1'b0; sat.in_a = '0; sat.in_b = '0; sat.out_ready = 1'b0;
    model_reset();

    // Reset values
    #3;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_sum",   {20'd0, bus.out_sum},   32'd0);
    check("rst_out_carry", {31'd0, bus.out_carry}, 32'd0);
    check("rst_adder_in",  {8'd0, adder_in},       32'd0);
    check("rst_op_count",  {16'd0, op_cnt},        32'd0);
    check("rst_carry_cnt", {16'd0, car_cnt},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors: push with out_ready low, inspect queued bus, capture, hand off.
    for (int i = 0; i < 8; i++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a      = vecs[i].a;
      bus.in_b      = vecs[i].b;
      cycle();
      bus.in_valid = 1'b0;
      check("vec_bus", {8'd0, adder_in}, {8'd0, vecs[i].exp_bus});
      check_all("vec_q");
      cycle();
      check("vec_valid", {31'd0, bus.out_valid}, 32'd1);
      check("vec_sum",   {20'd0, bus.out_sum},   {20'd0, vecs[i].exp_sum});
      check("vec_carry", {31'd0, bus.out_carry}, {31'd0, vecs[i].exp_carry});
      check_all("vec_cap");
      bus.out_ready = 1'b1;
      cycle();
      check("vec_drain", {31'd0, bus.out_valid}, 32'd0);
      check("vec_ops",   {16'd0, op_cnt}, i + 1);
      check_all("vec_done");
    end

    // Back-pressure: three pushes fill result register plus FIFO.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 12'(i);
      bus.in_b = 12'(i);
      cycle();
      check_all("bp_push");
    end
    bus.in_valid = 1'b0;
    check("bp_full", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold_sum", {20'd0, bus.out_sum}, 32'h002);
      check("bp_hold_vld", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    cycle();
    check("bp_r2", {20'd0, bus.out_sum}, 32'h004);
    check_all("bp_r2");
    cycle();
    check("bp_r3", {20'd0, bus.out_sum}, 32'h006);
    check("bp_r3_vld", {31'd0, bus.out_valid}, 32'd1);
    cycle();
    check("bp_empty", {31'd0, bus.out_valid}, 32'd0);
    check_all("bp_end");

    // Reset mid-operation: two queued entries plus a held result.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 12'h100 + 12'(i);
      bus.in_b = 12'h010;
      cycle();
    end
    bus.in_valid = 1'b0;
    check("mr_pre_vld",  {31'd0, bus.out_valid}, 32'd1);
    check("mr_pre_full", {31'd0, bus.in_ready},  32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mr_vld",   {31'd0, bus.out_valid}, 32'd0);
    check("mr_rdy",   {31'd0, bus.in_ready},  32'd1);
    check("mr_sum",   {20'd0, bus.out_sum},   32'd0);
    check("mr_bus",   {8'd0, adder_in},       32'd0);
    check("mr_ops",   {16'd0, op_cnt},        32'd0);
    check("mr_carry", {16'd0, car_cnt},       32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("mr_after_vld", {31'd0, bus.out_valid}, 32'd0);
      check_all("mr_after");
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.in_a      = 12'($urandom);
      bus.in_b      = 12'($urandom);
      bus.out_ready = ($urandom_range(2) != 0);
      cycle();
      check_all("rnd");
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check_all("rnd_flush");

    // Saturation on the 4-bit counter instance: 17 carrying operations.
    sat.out_ready = 1'b1;
    sat.in_a = 12'h800;
    sat.in_b = 12'h800;
    for (int i = 0; i < 17; i++) begin
      sat.in_valid = 1'b1;
      if (i > 0) check("sat_ready", {31'd0, sat.in_ready}, 32'd1);
      cycle();
    end
    sat.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("sat_ops",   {28'd0, s_op},  32'd15);
    check("sat_carry", {28'd0, s_car}, 32'd15);
    check("sat_vld",   {31'd0, sat.out_valid}, 32'd0);
    check("sat_sum",   {20'd0, sat.out_sum},   32'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
